ff_bank_arbiter: RTL and testbench

- Shares one WIDTH-bit register bank with JK-style bit semantics between NUM_REQ requesters.
- Each requester uses a valid/ready handshake to issue a masked bit operation: load, set (J), clear (K) or toggle (J&K).
- Arbitration is round-robin, with an optional lock that gives one requester exclusive access for a burst.
- Sits between control agents and the shared flip-flop state; it is the only writer of that state.

---
 rtl/ff_bank_pkg.sv | 14 +
 rtl/ff_bank_arbiter_rr_pick.sv | 30 +++
 rtl/ff_bank_arbiter.sv | 145 ++++++++++++++
 tb/tb_ff_bank_arbiter.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// rtl/ff_bank_pkg.sv - shared op and state encodings for the flip-flop bank arbiter
package ff_bank_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_SET    = 2'b01;
  localparam logic [1:0] OP_CLEAR  = 2'b10;
  localparam logic [1:0] OP_TOGGLE = 2'b11;

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } state_t;

endpackage

// File: rtl/ff_bank_arbiter_rr_pick.sv
// rtl/ff_bank_arbiter_rr_pick.sv - combinational round-robin picker, first valid at or above pointer
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] i_valid,
  input  logic [ID_W-1:0]    i_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_idx,
  output logic               o_any
);

  // Outer loop is the search distance from the pointer, so the nearest valid wins.
  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!o_any && i_valid[i] &&
            ((int'(i_ptr) + k == i) || (int'(i_ptr) + k == i + NUM_REQ))) begin
          o_any      = 1'b1;
          o_grant[i] = 1'b1;
          o_idx      = ID_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/ff_bank_arbiter.sv
// rtl/ff_bank_arbiter.sv - round-robin arbiter with lock, sole writer of a JK-style bit bank
module ff_bank_arbiter
  import ff_bank_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8,
  parameter int ID_W    = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [2*NUM_REQ-1:0]     req_op,
  input  logic [WIDTH*NUM_REQ-1:0] req_mask,
  input  logic [WIDTH*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]       req_lock,
  output logic [WIDTH-1:0]         q,
  output logic                     done_valid,
  output logic [ID_W-1:0]          done_id,
  output logic                     locked,
  output logic [ID_W-1:0]          lock_owner
);

  state_t               r_state;
  logic [ID_W-1:0]      r_ptr;
  logic [ID_W-1:0]      r_owner;
  logic                 r_stg_valid;
  logic [1:0]           r_stg_op;
  logic [WIDTH-1:0]     r_stg_mask;
  logic [WIDTH-1:0]     r_stg_data;
  logic [ID_W-1:0]      r_stg_id;
  logic [WIDTH-1:0]     r_q;
  logic                 r_done_valid;
  logic [ID_W-1:0]      r_done_id;

  logic [NUM_REQ-1:0]   w_rr_grant;
  logic [ID_W-1:0]      w_rr_idx;
  logic                 w_rr_any;
  logic [NUM_REQ-1:0]   w_lock_grant;
  logic [NUM_REQ-1:0]   w_grant;
  logic [ID_W-1:0]      w_idx;
  logic [ID_W-1:0]      w_idx_inc;
  logic                 w_xfer;
  logic [1:0]           w_sel_op;
  logic [WIDTH-1:0]     w_sel_mask;
  logic [WIDTH-1:0]     w_sel_data;
  logic                 w_sel_lock;

  rr_pick #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_ptr),
    .o_grant (w_rr_grant),
    .o_idx   (w_rr_idx),
    .o_any   (w_rr_any)
  );

  always_comb begin
    w_lock_grant = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      w_lock_grant[i] = req_valid[i] && (ID_W'(i) == r_owner);
    end
  end

  // Ready is forced low during reset so nothing can transfer while the bank is cleared.
  assign w_grant   = !reset_n ? '0 :
                     (r_state == ST_LOCKED) ? w_lock_grant : w_rr_grant;
  assign w_idx     = (r_state == ST_LOCKED) ? r_owner : w_rr_idx;
  assign w_xfer    = |w_grant;
  assign w_idx_inc = (w_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_idx + ID_W'(1);
  assign req_ready = w_grant;

  always_comb begin
    w_sel_op   = '0;
    w_sel_mask = '0;
    w_sel_data = '0;
    w_sel_lock = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_grant[i]) begin
        w_sel_op   = req_op[2*i +: 2];
        w_sel_mask = req_mask[WIDTH*i +: WIDTH];
        w_sel_data = req_data[WIDTH*i +: WIDTH];
        w_sel_lock = req_lock[i];
      end
    end
  end

  function automatic logic [WIDTH-1:0] apply_op(input logic [WIDTH-1:0] cur,
                                                input logic [1:0]       op,
                                                input logic [WIDTH-1:0] mask,
                                                input logic [WIDTH-1:0] data);
    case (op)
      OP_LOAD:  apply_op = (cur & ~mask) | (data & mask);
      OP_SET:   apply_op = cur | mask;
      OP_CLEAR: apply_op = cur & ~mask;
      default:  apply_op = cur ^ mask;
    endcase
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= ST_UNLOCKED;
      r_ptr        <= '0;
      r_owner      <= '0;
      r_stg_valid  <= 1'b0;
      r_stg_op     <= '0;
      r_stg_mask   <= '0;
      r_stg_data   <= '0;
      r_stg_id     <= '0;
      r_q          <= '0;
      r_done_valid <= 1'b0;
      r_done_id    <= '0;
    end else begin
      r_stg_valid <= w_xfer;
      if (w_xfer) begin
        r_stg_op   <= w_sel_op;
        r_stg_mask <= w_sel_mask;
        r_stg_data <= w_sel_data;
        r_stg_id   <= w_idx;
        // A locked owner that keeps the lock leaves the pointer parked.
        if (r_state == ST_UNLOCKED || !w_sel_lock) begin
          r_ptr <= w_idx_inc;
        end
        if (w_sel_lock) begin
          r_state <= ST_LOCKED;
          r_owner <= w_idx;
        end else begin
          r_state <= ST_UNLOCKED;
          r_owner <= '0;
        end
      end
      r_done_valid <= r_stg_valid;
      if (r_stg_valid) begin
        r_done_id <= r_stg_id;
        r_q       <= apply_op(r_q, r_stg_op, r_stg_mask, r_stg_data);
      end
    end
  end

  assign q          = r_q;
  assign done_valid = r_done_valid;
  assign done_id    = r_done_id;
  assign locked     = (r_state == ST_LOCKED);
  assign lock_owner = r_owner;

endmodule

// File: tb/tb_ff_bank_arbiter.sv
// tb/tb_ff_bank_arbiter.sv - directed vector bench for ff_bank_arbiter
module tb_ff_bank_arbiter;

  logic        clk;
  logic        reset_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_mask;
  logic [31:0] req_data;
  logic [3:0]  req_lock;
  logic [7:0]  q;
  logic        done_valid;
  logic [1:0]  done_id;
  logic        locked;
  logic [1:0]  lock_owner;

  int n_chk;
  int n_fail;

  ff_bank_arbiter #(.NUM_REQ(4), .WIDTH(8), .ID_W(2)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_mask   (req_mask),
    .req_data   (req_data),
    .req_lock   (req_lock),
    .q          (q),
    .done_valid (done_valid),
    .done_id    (done_id),
    .locked     (locked),
    .lock_owner (lock_owner)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  op;
    logic [31:0] mask;
    logic [31:0] data;
    logic [3:0]  lock;
    logic [3:0]  e_ready;
    logic [7:0]  e_q;
    logic        e_dv;
    logic [1:0]  e_did;
    logic        e_locked;
    logic [1:0]  e_owner;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [3:0] v, input logic [7:0] op, input logic [31:0] m,
                     input logic [31:0] d, input logic [3:0] lk, input logic [3:0] er,
                     input logic [7:0] eq, input logic edv, input logic [1:0] edid,
                     input logic elk, input logic [1:0] eown);
    vec_t t;
    t.valid = v; t.op = op; t.mask = m; t.data = d; t.lock = lk;
    t.e_ready = er; t.e_q = eq; t.e_dv = edv; t.e_did = edid;
    t.e_locked = elk; t.e_owner = eown;
    vecs.push_back(t);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] v, input logic [7:0] op, input logic [31:0] m,
                       input logic [31:0] d, input logic [3:0] lk);
    req_valid = v; req_op = op; req_mask = m; req_data = d; req_lock = lk;
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    reset_n = 1'b0;
    drive(4'b1111, 8'h55, 32'hFFFFFFFF, 32'h0, 4'b0000);

    // valid, op, mask, data, lock | ready, q, dv, did, locked, owner
    add(4'b1111, 8'h55, 32'h08040201, 32'h0, 4'b0000, 4'b0001, 8'h00, 0, 0, 0, 0);
    add(4'b1110, 8'h55, 32'h08040201, 32'h0, 4'b0000, 4'b0010, 8'h00, 0, 0, 0, 0);
    add(4'b1100, 8'h55, 32'h08040201, 32'h0, 4'b0000, 4'b0100, 8'h01, 1, 0, 0, 0);
    add(4'b1000, 8'h55, 32'h08040201, 32'h0, 4'b0000, 4'b1000, 8'h03, 1, 1, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'h07, 1, 2, 0, 0);
    add(4'b0100, 8'h30, 32'h00FF0000, 32'h0, 4'b0000, 4'b0100, 8'h0F, 1, 3, 0, 0);
    add(4'b1000, 8'h80, 32'hF0000000, 32'h0, 4'b0000, 4'b1000, 8'h0F, 0, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hF0, 1, 2, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'h00, 1, 3, 0, 0);
    add(4'b0010, 8'h00, 32'h0000FF00, 32'h0000A500, 4'b0000, 4'b0010, 8'h00, 0, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'h00, 0, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hA5, 1, 1, 0, 0);
    add(4'b0010, 8'h00, 32'h0,        32'h0000FF00, 4'b0000, 4'b0010, 8'hA5, 0, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hA5, 0, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hA5, 1, 1, 0, 0);
    add(4'b0001, 8'h01, 32'h00000010, 32'h0, 4'b0000, 4'b0001, 8'hA5, 0, 0, 0, 0);
    add(4'b0111, 8'h1D, 32'h00080140, 32'h0, 4'b0010, 4'b0010, 8'hA5, 0, 0, 0, 0);
    add(4'b0111, 8'h1D, 32'h00080140, 32'h0, 4'b0010, 4'b0010, 8'hB5, 1, 0, 1, 1);
    add(4'b0111, 8'h1D, 32'h00080140, 32'h0, 4'b0010, 4'b0010, 8'hB4, 1, 1, 1, 1);
    add(4'b0111, 8'h1D, 32'h00080140, 32'h0, 4'b0010, 4'b0010, 8'hB5, 1, 1, 1, 1);
    add(4'b0111, 8'h1D, 32'h00080140, 32'h0, 4'b0000, 4'b0010, 8'hB4, 1, 1, 1, 1);
    add(4'b0101, 8'h1D, 32'h00080140, 32'h0, 4'b0000, 4'b0100, 8'hB5, 1, 1, 0, 0);
    add(4'b0001, 8'h1D, 32'h00080140, 32'h0, 4'b0000, 4'b0001, 8'hB4, 1, 1, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hBC, 1, 2, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hFC, 1, 0, 0, 0);
    add(4'b0000, 8'h00, 32'h0,        32'h0, 4'b0000, 4'b0000, 8'hFC, 0, 0, 0, 0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_ready", 32'(req_ready), 32'h0);
    chk("reset_q", 32'(q), 32'h0);
    chk("reset_done", 32'(done_valid), 32'h0);
    chk("reset_locked", 32'(locked), 32'h0);
    chk("reset_owner", 32'(lock_owner), 32'h0);
    @(posedge clk);
    #1;
    drive(4'b0000, 8'h0, 32'h0, 32'h0, 4'b0000);
    reset_n = 1'b1;

    for (int r = 0; r < vecs.size(); r++) begin
      @(posedge clk);
      #1;
      drive(vecs[r].valid, vecs[r].op, vecs[r].mask, vecs[r].data, vecs[r].lock);
      @(negedge clk);
      chk($sformatf("row%0d_ready", r), 32'(req_ready), 32'(vecs[r].e_ready));
      chk($sformatf("row%0d_q", r), 32'(q), 32'(vecs[r].e_q));
      chk($sformatf("row%0d_done_valid", r), 32'(done_valid), 32'(vecs[r].e_dv));
      if (vecs[r].e_dv)
        chk($sformatf("row%0d_done_id", r), 32'(done_id), 32'(vecs[r].e_did));
      chk($sformatf("row%0d_locked", r), 32'(locked), 32'(vecs[r].e_locked));
      chk($sformatf("row%0d_owner", r), 32'(lock_owner), 32'(vecs[r].e_owner));
    end

    // Lock held by req 3 with an op staged, then reset lands one cycle after the accept.
    @(posedge clk);
    #1;
    drive(4'b1000, 8'h40, 32'h01000000, 32'h0, 4'b1000);
    @(negedge clk);
    chk("mid_ready3", 32'(req_ready), 32'b1000);
    @(posedge clk);
    #1;
    chk("mid_locked", 32'(locked), 32'h1);
    chk("mid_owner", 32'(lock_owner), 32'h3);
    drive(4'b1111, 8'h55, 32'h80808080, 32'h0, 4'b0000);
    reset_n = 1'b0;
    #1;
    chk("rst_ready", 32'(req_ready), 32'h0);
    chk("rst_q", 32'(q), 32'h0);
    chk("rst_locked", 32'(locked), 32'h0);
    chk("rst_owner", 32'(lock_owner), 32'h0);
    chk("rst_done", 32'(done_valid), 32'h0);
    @(negedge clk);
    chk("rst_hold_ready", 32'(req_ready), 32'h0);
    @(posedge clk);
    #1;
    chk("rst_hold_done", 32'(done_valid), 32'h0);
    reset_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(req_ready), 32'b0001);
    @(posedge clk);
    #1;
    drive(4'b0000, 8'h0, 32'h0, 32'h0, 4'b0000);
    @(negedge clk);
    chk("post_rst_no_stale_done", 32'(done_valid), 32'h0);
    chk("post_rst_q0", 32'(q), 32'h0);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_done", 32'(done_valid), 32'h1);
    chk("post_rst_done_id", 32'(done_id), 32'h0);
    chk("post_rst_q", 32'(q), 32'h80);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("post_rst_done_end", 32'(done_valid), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
